// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction-word constants and sequencer state encoding
package cpu_pkg;

  localparam int INSTR_WIDTH  = 32;
  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 28;
  localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/instruction_fifo.sv
// rtl/instruction_fifo.sv - issue buffer holding fetched words with their addresses
// Flush empties the buffer and wins over a simultaneous push or pop.
module instruction_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int DATA_WIDTH  = INSTR_WIDTH,
  parameter int ADDR_WIDTH  = 6,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic [ADDR_WIDTH-1:0]  push_addr,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  head_data,
  output logic [ADDR_WIDTH-1:0]  head_addr,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   do_push;
  logic                   do_pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_q != '0) && !flush;
  assign do_push = push && !flush && ((count_q != COUNT_WIDTH'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr] <= push_data;
      addr_mem[wr_ptr] <= push_addr;
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_addr = addr_mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetches base..end from instruction memory and streams it to the cpu
// Run control FSM and fetch counter; fetched words queue in instruction_fifo.
module instruction_sequencer #(
  parameter int ADDR_WIDTH  = 6,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   start_in,
  input  logic                   abort_in,
  input  logic [ADDR_WIDTH-1:0]  base_addr_in,
  input  logic [ADDR_WIDTH-1:0]  end_addr_in,
  output logic                   imem_rd_en_out,
  output logic [ADDR_WIDTH-1:0]  imem_rd_addr_out,
  input  logic [INSTR_WIDTH-1:0] imem_rd_data_in,
  input  logic                   cpu_ready_in,
  output logic                   instr_valid_out,
  output logic [INSTR_WIDTH-1:0] current_instruction_out,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   busy_out,
  output logic                   done_out
);

  import cpu_pkg::*;

  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_WIDTH   = COUNT_WIDTH + 1;

  seq_state_e state_q;
  seq_state_e state_d;

  // One extra bit so an end address of all-ones still terminates the fetch.
  logic [ADDR_WIDTH:0]   fetch_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;

  logic [COUNT_WIDTH-1:0] fifo_count;
  logic [INSTR_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0]  head_addr;

  logic                 running;
  logic                 fifo_valid;
  logic                 handshake;
  logic                 halt_hit;
  logic                 flush;
  logic                 fetch_in_range;
  logic                 fetch_is_last;
  logic [OCC_WIDTH-1:0] occupancy;
  logic                 room;
  logic                 rd_en;

  assign running        = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
  assign fifo_valid     = running && (fifo_count != '0);
  assign handshake      = fifo_valid && cpu_ready_in;
  assign halt_hit       = handshake && (head_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  assign flush          = running && (abort_in || halt_hit);
  assign fetch_in_range = fetch_q <= {1'b0, end_q};
  assign fetch_is_last  = fetch_q == {1'b0, end_q};

  // Count the in-flight word as already occupying a slot, and credit this cycle's pop.
  assign occupancy = OCC_WIDTH'(fifo_count) + OCC_WIDTH'(inflight_q) - OCC_WIDTH'(handshake);
  assign room      = occupancy < OCC_WIDTH'(FIFO_DEPTH);
  assign rd_en     = (state_q == SEQ_RUN) && fetch_in_range && room && !flush;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q         <= SEQ_IDLE;
      fetch_q         <= '0;
      end_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (rd_en) inflight_addr_q <= fetch_q[ADDR_WIDTH-1:0];
      if ((state_q == SEQ_IDLE) && start_in) begin
        fetch_q <= {1'b0, base_addr_in};
        end_q   <= end_addr_in;
      end else if (rd_en) begin
        fetch_q <= fetch_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start_in) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (abort_in)                   state_d = SEQ_IDLE;
        else if (halt_hit)              state_d = SEQ_DONE;
        else if (!fetch_in_range)       state_d = SEQ_DONE;
        else if (rd_en && fetch_is_last) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (abort_in)      state_d = SEQ_IDLE;
        else if (halt_hit) state_d = SEQ_DONE;
        else if (handshake && (fifo_count == COUNT_WIDTH'(1)) && !inflight_q)
          state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  instruction_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_fifo (
    .clk      (clock_in),
    .rst_n    (reset_n_in),
    .flush    (flush),
    .push     (inflight_q),
    .push_data(imem_rd_data_in),
    .push_addr(inflight_addr_q),
    .pop      (handshake),
    .head_data(head_data),
    .head_addr(head_addr),
    .count    (fifo_count)
  );

  assign imem_rd_en_out          = rd_en;
  assign imem_rd_addr_out        = rd_en ? fetch_q[ADDR_WIDTH-1:0] : '0;
  assign instr_valid_out         = fifo_valid;
  assign current_instruction_out = fifo_valid ? head_data : '0;
  assign pc_out                  = fifo_valid ? head_addr : '0;
  assign busy_out                = state_q != SEQ_IDLE;
  assign done_out                = state_q == SEQ_DONE;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - randomized self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic        abort_in;
  logic [5:0]  base_addr_in;
  logic [5:0]  end_addr_in;
  logic        imem_rd_en_out;
  logic [5:0]  imem_rd_addr_out;
  logic [31:0] imem_rd_data_in;
  logic        cpu_ready_in;
  logic        instr_valid_out;
  logic [31:0] current_instruction_out;
  logic [5:0]  pc_out;
  logic        busy_out;
  logic        done_out;

  logic [31:0] mem [64];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.ADDR_WIDTH(6), .INSTR_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clock_in               (clk),
    .reset_n_in             (reset_n_in),
    .start_in               (start_in),
    .abort_in               (abort_in),
    .base_addr_in           (base_addr_in),
    .end_addr_in            (end_addr_in),
    .imem_rd_en_out         (imem_rd_en_out),
    .imem_rd_addr_out       (imem_rd_addr_out),
    .imem_rd_data_in        (imem_rd_data_in),
    .cpu_ready_in           (cpu_ready_in),
    .instr_valid_out        (instr_valid_out),
    .current_instruction_out(current_instruction_out),
    .pc_out                 (pc_out),
    .busy_out               (busy_out),
    .done_out               (done_out)
  );

  // Synchronous-read memory; returns junk when not strobed.
  always @(posedge clk) imem_rd_data_in <= imem_rd_en_out ? mem[imem_rd_addr_out] : $urandom;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] all_outputs();
    return {busy_out, instr_valid_out, done_out, imem_rd_en_out,
            current_instruction_out, pc_out, imem_rd_addr_out};
  endfunction

  task automatic fill_mem();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w[31:28] == 4'hF) w[31:28] = 4'hE;
      mem[i] = w;
    end
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low for cycles 3..5
  task automatic run_prog(input int base, input int last, input int rmode, input bit do_abort);
    logic [31:0] exp_i[$];
    int          exp_pc[$];
    bit          halt_in_range;
    int          exp_len, first_valid, done_k, n_done, n_strobe, n_hs, ep;
    bit          prev_stall, aborted, abort_checked, hs;
    logic [31:0] prev_i, ei;
    logic [5:0]  prev_pc, ep6, b6;
    logic [6:0]  exp_s0;

    halt_in_range = 1'b0;
    for (int a = base; a <= last && !halt_in_range; a++) begin
      exp_i.push_back(mem[a]);
      exp_pc.push_back(a);
      if (mem[a][31:28] == 4'hF) halt_in_range = 1'b1;
    end
    exp_len = exp_i.size();
    b6 = base[5:0];
    exp_s0 = (base <= last) ? {1'b1, b6} : 7'd0;

    base_addr_in = base[5:0];
    end_addr_in  = last[5:0];
    start_in     = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;

    first_valid = -1; done_k = -1; n_done = 0; n_strobe = 0; n_hs = 0;
    prev_stall = 0; aborted = 0; abort_checked = 0; prev_i = '0; prev_pc = '0;

    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      case (rmode)
        0:       cpu_ready_in = 1'b1;
        1:       cpu_ready_in = ($urandom_range(0, 3) != 0);
        default: cpu_ready_in = !(k >= 3 && k <= 5);
      endcase
      abort_in = do_abort && !aborted && instr_valid_out && (pc_out == 6'd2);
      if (abort_in) cpu_ready_in = 1'b1;
      if (rmode == 1 && done_k < 0 && k > 0 && $urandom_range(0, 5) == 0) begin
        start_in     = 1'b1;
        base_addr_in = 6'($urandom);
        end_addr_in  = 6'($urandom);
      end else begin
        start_in = 1'b0;
      end
      @(negedge clk);

      if (aborted) begin
        check("abort_idle", {all_outputs(), 16'h0}, 64'h0);
        abort_checked = 1'b1;
        break;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        check("post_done_idle", {busy_out, done_out}, 2'b00);
        break;
      end

      if (k == 0) check("strobe_first", {imem_rd_en_out, imem_rd_addr_out}, exp_s0);
      if (rmode == 2 && k >= 3 && k <= 5) check("stall_rd", imem_rd_en_out, 1'b0);

      hs = instr_valid_out && cpu_ready_in;
      if (imem_rd_en_out) begin
        check("strobe_addr", imem_rd_addr_out, base + n_strobe);
        n_strobe++;
      end
      if (hs) n_hs++;
      if (imem_rd_en_out) check("outstanding", (n_strobe - n_hs) <= 2, 1'b1);

      if (instr_valid_out) begin
        if (first_valid < 0) first_valid = k;
        if (prev_stall) check("stable", {current_instruction_out, pc_out}, {prev_i, prev_pc});
        if (cpu_ready_in && !abort_in) begin
          if (exp_i.size() == 0) begin
            check("extra_issue", {current_instruction_out, pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            ei = exp_i.pop_front();
            ep = exp_pc.pop_front();
            ep6 = ep[5:0];
            check("issue", {current_instruction_out, pc_out}, {ei, ep6});
          end
        end
        prev_stall = !cpu_ready_in;
        prev_i     = current_instruction_out;
        prev_pc    = pc_out;
      end else begin
        prev_stall = 1'b0;
        check("idle_zero", {current_instruction_out, pc_out}, 38'h0);
      end

      if (done_out) begin
        n_done++;
        if (done_k < 0) done_k = k;
        check("done_busy", busy_out, 1'b1);
      end
      if (abort_in) aborted = 1'b1;
    end
    abort_in = 1'b0;
    start_in = 1'b0;

    if (do_abort) begin
      check("abort_taken", abort_checked, 1'b1);
      check("abort_no_done", n_done, 0);
    end else begin
      check("done_once", n_done, 1);
      check("all_issued", exp_i.size(), 0);
      check("first_valid", first_valid, (base <= last) ? 2 : -1);
      if (rmode == 0) check("done_cycle", done_k, (base <= last) ? 2 + exp_len : 1);
      if (!halt_in_range) check("strobe_count", n_strobe, (base <= last) ? last - base + 1 : 0);
    end
  endtask

  task automatic reset_mid_run();
    base_addr_in = 6'd0;
    end_addr_in  = 6'd30;
    cpu_ready_in = 1'b1;
    start_in     = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;
    repeat (4) @(posedge clk);
    #2 check("run_active", {busy_out, instr_valid_out}, 2'b11);
    #1 reset_n_in = 1'b0;
    #1 check("rst_async", all_outputs(), 48'h0);
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_held", all_outputs(), 48'h0);
    @(negedge clk) reset_n_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet", all_outputs(), 48'h0);
    end
  endtask

  initial begin
    int base, last, h;
    reset_n_in   = 1'b0;
    start_in     = 1'b0;
    abort_in     = 1'b0;
    cpu_ready_in = 1'b0;
    base_addr_in = '0;
    end_addr_in  = '0;
    fill_mem();
    #1 check("reset_outputs", all_outputs(), 48'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n_in = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outputs(), 48'h0);

    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    run_prog(0, 3, 0, 0);
    run_prog(0, 3, 2, 0);

    fill_mem();
    mem[1] = 32'hF000_0000;
    run_prog(0, 5, 0, 0);
    run_prog(5, 4, 0, 0);

    fill_mem();
    run_prog(58, 63, 0, 0);
    run_prog(60, 63, 1, 0);
    run_prog(0, 5, 0, 1);
    run_prog(0, 5, 0, 0);

    reset_mid_run();
    run_prog(2, 7, 0, 0);

    for (int r = 0; r < 24; r++) begin
      fill_mem();
      base = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0 && base > 0) last = base - 1;
      else begin
        last = base + $urandom_range(0, 12);
        if (last > 63) last = 63;
      end
      if (base <= last && $urandom_range(0, 2) == 0) begin
        h = $urandom_range(base, last);
        mem[h][31:28] = 4'hF;
      end
      run_prog(base, last, $urandom_range(0, 1), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
